// File: rtl/axi_scratch_regfile.sv
// AXI4 slave scratch register file: independent write/read burst engines over a
// small word array, with the low byte of word 0 exported for LEDs/Pmod.
module axi_scratch_regfile #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH_LOG2 = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic                    s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic                    s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic                    s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [7:0]              scratch_out
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] IDX_ONE = 1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    function automatic logic f_hit(input logic [ADDR_WIDTH-1:0] a);
        return a[ADDR_WIDTH-1:DEPTH_LOG2+2] == BASE_ADDR[ADDR_WIDTH-1:DEPTH_LOG2+2];
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [7:0]            r_scratch;

    w_state_t              r_wstate, w_wstate_nxt;
    logic                  r_awready;
    logic                  r_wid;
    logic [DEPTH_LOG2-1:0] r_widx;
    logic [7:0]            r_wlen, r_wcnt;
    logic                  r_wfixed, r_wdec, r_wslv, r_wlast_err;
    logic                  w_aw_hs, w_w_hs, w_wfinal;

    r_state_t              r_rstate, w_rstate_nxt;
    logic                  r_arready;
    logic                  r_rid;
    logic [DEPTH_LOG2-1:0] r_ridx;
    logic [7:0]            r_rlen, r_rcnt;
    logic                  r_rfixed, r_rerr, r_rlast;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  w_ar_hs, w_r_hs, w_ar_bad;
    logic [1:0]            w_ar_resp;
    logic [DEPTH_LOG2-1:0] w_ar_idx;
    logic [7:0]            w_rcnt_nxt;
    logic                  w_unused_ok;

    assign w_aw_hs   = r_awready && s_axi_awvalid;
    assign w_w_hs    = (r_wstate == W_DATA) && s_axi_wvalid;
    assign w_wfinal  = (r_wcnt == r_wlen);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_wstate <= W_IDLE;
        else          r_wstate <= w_wstate_nxt;
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
            W_DATA:  if (w_w_hs && w_wfinal) w_wstate_nxt = W_RESP;
            W_RESP:  if (s_axi_bready) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // The beat counter, not wlast, terminates the burst; wlast only grades the response.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
            r_scratch   <= '0;
            r_awready   <= 1'b0;
            r_wid       <= 1'b0;
            r_widx      <= '0;
            r_wlen      <= '0;
            r_wcnt      <= '0;
            r_wfixed    <= 1'b0;
            r_wdec      <= 1'b0;
            r_wslv      <= 1'b0;
            r_wlast_err <= 1'b0;
        end else begin
            r_awready <= (w_wstate_nxt == W_IDLE);
            if (w_aw_hs) begin
                r_wid       <= s_axi_awid;
                r_widx      <= s_axi_awaddr[DEPTH_LOG2+1:2];
                r_wlen      <= s_axi_awlen;
                r_wcnt      <= '0;
                r_wfixed    <= (s_axi_awburst == 2'b00);
                r_wdec      <= !f_hit(s_axi_awaddr);
                r_wslv      <= s_axi_awburst[1];
                r_wlast_err <= 1'b0;
            end
            if (w_w_hs) begin
                if (!r_wdec && !r_wslv) begin
                    for (int b = 0; b < DATA_WIDTH/8; b++) begin
                        if (s_axi_wstrb[b]) r_mem[r_widx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                    end
                    if (r_widx == '0 && s_axi_wstrb[0]) r_scratch <= s_axi_wdata[7:0];
                end
                if (!r_wfixed) r_widx <= r_widx + IDX_ONE;
                r_wcnt <= r_wcnt + 8'd1;
                if (s_axi_wlast != w_wfinal) r_wlast_err <= 1'b1;
            end
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = (r_wstate == W_DATA);
    assign s_axi_bvalid  = (r_wstate == W_RESP);
    assign s_axi_bid     = r_wid;
    assign s_axi_bresp   = r_wdec ? 2'b11 : ((r_wslv || r_wlast_err) ? 2'b10 : 2'b00);
    assign scratch_out   = r_scratch;

    assign w_ar_hs    = r_arready && s_axi_arvalid;
    assign w_r_hs     = (r_rstate == R_DATA) && s_axi_rready;
    assign w_ar_idx   = s_axi_araddr[DEPTH_LOG2+1:2];
    assign w_ar_bad   = !f_hit(s_axi_araddr) || s_axi_arburst[1];
    assign w_ar_resp  = !f_hit(s_axi_araddr) ? 2'b11 : (s_axi_arburst[1] ? 2'b10 : 2'b00);
    assign w_rcnt_nxt = r_rcnt + 8'd1;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_rstate <= R_IDLE;
        else          r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
            R_DATA:  if (w_r_hs && r_rcnt == r_rlen) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // r_ridx always points at the word for the next beat to be loaded.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_arready <= 1'b0;
            r_rid     <= 1'b0;
            r_ridx    <= '0;
            r_rlen    <= '0;
            r_rcnt    <= '0;
            r_rfixed  <= 1'b0;
            r_rerr    <= 1'b0;
            r_rresp   <= 2'b00;
            r_rdata   <= '0;
            r_rlast   <= 1'b0;
        end else begin
            r_arready <= (w_rstate_nxt == R_IDLE);
            if (w_ar_hs) begin
                r_rid    <= s_axi_arid;
                r_rlen   <= s_axi_arlen;
                r_rcnt   <= '0;
                r_rfixed <= (s_axi_arburst == 2'b00);
                r_rerr   <= w_ar_bad;
                r_rresp  <= w_ar_resp;
                r_rdata  <= w_ar_bad ? '0 : r_mem[w_ar_idx];
                r_rlast  <= (s_axi_arlen == 8'd0);
                r_ridx   <= (s_axi_arburst == 2'b00) ? w_ar_idx : w_ar_idx + IDX_ONE;
            end else if (w_r_hs && r_rcnt != r_rlen) begin
                r_rdata <= r_rerr ? '0 : r_mem[r_ridx];
                r_rcnt  <= w_rcnt_nxt;
                r_rlast <= (w_rcnt_nxt == r_rlen);
                if (!r_rfixed) r_ridx <= r_ridx + IDX_ONE;
            end
        end
    end

    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = (r_rstate == R_DATA);
    assign s_axi_rid     = r_rid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rlast   = r_rlast;

    assign w_unused_ok = &{1'b0, s_axi_awaddr[1:0], s_axi_araddr[1:0]};
endmodule

// File: tb/tb_axi_scratch_regfile.sv
// Directed bench for axi_scratch_regfile: drivers push expected B/R responses into
// queues, a negedge monitor pops and compares on every handshake.
module tb_axi_scratch_regfile;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        s_axi_awid = 1'b0;
    logic [31:0] s_axi_awaddr = '0;
    logic [7:0]  s_axi_awlen = '0;
    logic [1:0]  s_axi_awburst = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wlast = 1'b0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic        s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic        s_axi_arid = 1'b0;
    logic [31:0] s_axi_araddr = '0;
    logic [7:0]  s_axi_arlen = '0;
    logic [1:0]  s_axi_arburst = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic        s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic [7:0]  scratch_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0]  exp_b_q[$];
    logic [35:0] exp_r_q[$];
    logic [31:0] wd [8];
    logic [3:0]  ws [8];

    axi_scratch_regfile #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(4), .BASE_ADDR(32'h0000_0000)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .scratch_out(scratch_out)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: no handshake within cycle budget", name);
    endtask

    task automatic push_r(input logic id, input logic [31:0] data, input logic [1:0] resp,
                          input logic last);
        exp_r_q.push_back({id, resp, last, data});
    endtask

    // All valid/ready handshakes: inputs change at posedge+1, ready sampled at negedge.
    task automatic axi_write(input logic id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic early, input logic [1:0] resp);
        int  n;
        logic hs;
        exp_b_q.push_back({id, resp});
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awburst = burst;
        s_axi_awvalid = 1'b1;
        n = 0; hs = 1'b0;
        while (!hs && n < 100) begin
            @(negedge aclk); hs = s_axi_awready; @(posedge aclk); #1; n++;
        end
        s_axi_awvalid = 1'b0;
        if (!hs) tmo("aw_handshake");
        for (int i = 0; i <= int'(len); i++) begin
            s_axi_wdata = wd[i]; s_axi_wstrb = ws[i];
            s_axi_wlast = early ? (i == 0) : (i == int'(len));
            s_axi_wvalid = 1'b1;
            n = 0; hs = 1'b0;
            while (!hs && n < 100) begin
                @(negedge aclk); hs = s_axi_wready; @(posedge aclk); #1; n++;
            end
            if (!hs) tmo("w_handshake");
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        s_axi_bready = 1'b1;
        n = 0; hs = 1'b0;
        while (!hs && n < 100) begin
            @(negedge aclk); hs = s_axi_bvalid; @(posedge aclk); #1; n++;
        end
        s_axi_bready = 1'b0;
        if (!hs) tmo("b_handshake");
    endtask

    task automatic axi_read(input logic id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic toggle);
        int  n;
        int  beats;
        logic hs;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        n = 0; hs = 1'b0;
        while (!hs && n < 100) begin
            @(negedge aclk); hs = s_axi_arready; @(posedge aclk); #1; n++;
        end
        s_axi_arvalid = 1'b0;
        if (!hs) tmo("ar_handshake");
        beats = 0; n = 0;
        while (beats <= int'(len) && n < 200) begin
            s_axi_rready = toggle ? (n % 2 == 0) : 1'b1;
            @(negedge aclk);
            if (s_axi_rvalid && s_axi_rready) beats++;
            @(posedge aclk); #1; n++;
        end
        s_axi_rready = 1'b0;
        if (beats <= int'(len)) tmo("r_beats");
    endtask

    always @(negedge aclk) begin
        logic [2:0]  eb;
        logic [35:0] er;
        if (aresetn && s_axi_bvalid && s_axi_bready) begin
            n_checks++;
            if (exp_b_q.size() == 0) begin
                n_fail++;
                $display("FAIL b_unexpected: got id=%0d resp=%b with empty queue", s_axi_bid, s_axi_bresp);
            end else begin
                eb = exp_b_q.pop_front();
                if ({s_axi_bid, s_axi_bresp} !== eb) begin
                    n_fail++;
                    $display("FAIL b_resp: got id=%0d resp=%b expected id=%0d resp=%b",
                             s_axi_bid, s_axi_bresp, eb[2], eb[1:0]);
                end
            end
        end
        if (aresetn && s_axi_rvalid && s_axi_rready) begin
            n_checks++;
            if (exp_r_q.size() == 0) begin
                n_fail++;
                $display("FAIL r_unexpected: got data=%h with empty queue", s_axi_rdata);
            end else begin
                er = exp_r_q.pop_front();
                if ({s_axi_rid, s_axi_rresp, s_axi_rlast, s_axi_rdata} !== er) begin
                    n_fail++;
                    $display("FAIL r_beat: got id=%0d resp=%b last=%b data=%h expected id=%0d resp=%b last=%b data=%h",
                             s_axi_rid, s_axi_rresp, s_axi_rlast, s_axi_rdata,
                             er[35], er[34:33], er[32], er[31:0]);
                end
            end
        end
    end

    initial begin
        int n;
        logic hs;
        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_awready", {35'd0, s_axi_awready}, 36'd0);
        chk("rst_arready", {35'd0, s_axi_arready}, 36'd0);
        chk("rst_valids", {32'd0, s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast}, 36'd0);
        chk("rst_resps", {32'd0, s_axi_bresp, s_axi_rresp}, 36'd0);
        chk("rst_rdata", {4'd0, s_axi_rdata}, 36'd0);
        chk("rst_scratch", {28'd0, scratch_out}, 36'd0);
        @(posedge aclk); #1 aresetn = 1'b1;
        repeat (2) @(posedge aclk); #1;

        // Single full-word write then readback
        wd[0] = 32'hCAFE_F00D; ws[0] = 4'hF;
        axi_write(1'b1, 32'h4, 8'd0, 2'b01, 1'b0, 2'b00);
        push_r(1'b1, 32'hCAFE_F00D, 2'b00, 1'b1);
        axi_read(1'b1, 32'h4, 8'd0, 2'b01, 1'b0);

        // Partial strobes
        wd[0] = 32'h1122_3344; ws[0] = 4'b0101;
        axi_write(1'b0, 32'h4, 8'd0, 2'b01, 1'b0, 2'b00);
        push_r(1'b0, 32'hCA22_F044, 2'b00, 1'b1);
        axi_read(1'b0, 32'h4, 8'd0, 2'b01, 1'b0);

        // INCR burst wrapping past the top word, throttled readback
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        axi_write(1'b0, 32'h38, 8'd3, 2'b01, 1'b0, 2'b00);
        for (int i = 0; i < 4; i++) push_r(1'b1, 32'(i + 1), 2'b00, i == 3);
        axi_read(1'b1, 32'h38, 8'd3, 2'b01, 1'b1);
        push_r(1'b0, 32'd3, 2'b00, 1'b1);
        axi_read(1'b0, 32'h0, 8'd0, 2'b01, 1'b0);
        push_r(1'b0, 32'd1, 2'b00, 1'b0);
        push_r(1'b0, 32'd1, 2'b00, 1'b1);
        axi_read(1'b0, 32'h38, 8'd1, 2'b00, 1'b0);

        // Out-of-range address
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
        axi_write(1'b1, 32'h100, 8'd0, 2'b01, 1'b0, 2'b11);
        push_r(1'b1, 32'd0, 2'b11, 1'b1);
        axi_read(1'b1, 32'h100, 8'd0, 2'b01, 1'b0);
        push_r(1'b0, 32'd3, 2'b00, 1'b1);
        axi_read(1'b0, 32'h0, 8'd0, 2'b01, 1'b0);

        // WRAP burst type is refused on both channels
        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
        axi_write(1'b0, 32'h14, 8'd0, 2'b10, 1'b0, 2'b10);
        push_r(1'b0, 32'd0, 2'b00, 1'b1);
        axi_read(1'b0, 32'h14, 8'd0, 2'b01, 1'b0);
        push_r(1'b1, 32'd0, 2'b10, 1'b1);
        axi_read(1'b1, 32'h14, 8'd0, 2'b11, 1'b0);

        // Early wlast with a concurrent unrelated read
        wd[0] = 32'h0000_0055; wd[1] = 32'h0000_0066; ws[0] = 4'hF; ws[1] = 4'hF;
        push_r(1'b1, 32'd0, 2'b00, 1'b1);
        fork
            axi_write(1'b1, 32'h20, 8'd1, 2'b01, 1'b1, 2'b10);
            axi_read(1'b1, 32'h8, 8'd0, 2'b01, 1'b0);
        join
        push_r(1'b0, 32'h55, 2'b00, 1'b0);
        push_r(1'b0, 32'h66, 2'b00, 1'b1);
        axi_read(1'b0, 32'h20, 8'd1, 2'b01, 1'b0);

        // scratch_out follows byte 0 of word 0
        @(negedge aclk);
        chk("scratch_before", {28'd0, scratch_out}, 36'h03);
        @(posedge aclk); #1;
        wd[0] = 32'h0000_00A5; ws[0] = 4'b0001;
        axi_write(1'b0, 32'h0, 8'd0, 2'b01, 1'b0, 2'b00);
        @(negedge aclk);
        chk("scratch_a5", {28'd0, scratch_out}, 36'hA5);
        @(posedge aclk); #1;

        // Reset in the middle of a read burst
        s_axi_arid = 1'b0; s_axi_araddr = 32'h0; s_axi_arlen = 8'd3; s_axi_arburst = 2'b01;
        s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
        n = 0; hs = 1'b0;
        while (!hs && n < 100) begin
            @(negedge aclk); hs = s_axi_arready; @(posedge aclk); #1; n++;
        end
        s_axi_arvalid = 1'b0;
        if (!hs) tmo("ar_before_reset");
        @(negedge aclk);
        chk("rvalid_beat0", {35'd0, s_axi_rvalid}, 36'd1);
        chk("rdata_beat0", {4'd0, s_axi_rdata}, {4'd0, 32'h0000_00A5});
        @(posedge aclk); #1 aresetn = 1'b0;
        #1;
        chk("rvalid_in_reset", {35'd0, s_axi_rvalid}, 36'd0);
        chk("scratch_in_reset", {28'd0, scratch_out}, 36'd0);
        repeat (2) @(posedge aclk); #1 aresetn = 1'b1;
        repeat (2) @(posedge aclk); #1;
        push_r(1'b0, 32'd0, 2'b00, 1'b1);
        axi_read(1'b0, 32'h0, 8'd0, 2'b01, 1'b0);
        push_r(1'b1, 32'd0, 2'b00, 1'b1);
        axi_read(1'b1, 32'h4, 8'd0, 2'b01, 1'b0);

        repeat (3) @(posedge aclk);
        chk("b_queue_drained", 36'(exp_b_q.size()), 36'd0);
        chk("r_queue_drained", 36'(exp_r_q.size()), 36'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_scratch_regfile.md
Name: axi_scratch_regfile

Overview:
AXI4 slave register file that sits directly downstream of the JTAG-to-AXI master in the demo firmware. It consumes the master's write and read transactions, storing 32-bit words in a small register array, so host-side JTAG scripts get a real target with responses and data readback. It also exports the low byte of word 0 for driving Pmod/LED outputs.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width; fixed at 32, byte lanes = 4
DEPTH_LOG2, 4, log2 of word count (default 16 words)
BASE_ADDR, 32'h0000_0000, region base; aligned to 4*2^DEPTH_LOG2

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
s_axi_awid  in  1  write ID
s_axi_awaddr  in  ADDR_WIDTH  write address
s_axi_awlen  in  8  beats-1
s_axi_awburst  in  2  burst type
s_axi_awvalid / s_axi_awready  in / out  1  AW handshake
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8  byte strobes
s_axi_wlast  in  1  final write beat
s_axi_wvalid / s_axi_wready  in / out  1  W handshake
s_axi_bid  out  1  echoed awid
s_axi_bresp  out  2  write response
s_axi_bvalid / s_axi_bready  out / in  1  B handshake
s_axi_arid  in  1  read ID
s_axi_araddr  in  ADDR_WIDTH  read address
s_axi_arlen  in  8  beats-1
s_axi_arburst  in  2  burst type
s_axi_arvalid / s_axi_arready  in / out  1  AR handshake
s_axi_rid  out  1  echoed arid
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  read response
s_axi_rlast  out  1  final read beat
s_axi_rvalid / s_axi_rready  out / in  1  R handshake
scratch_out  out  8  word 0 bits [7:0], registered

Behaviour:
- Reset (async assert, sync-deassert handled upstream): all valids/readies 0, bresp/rresp 0, rdata 0, rlast 0, bid/rid 0, every array word 0, scratch_out 0. Reset mid-burst aborts the transaction; no response issued.
- Decode: hit when addr[ADDR_WIDTH-1:DEPTH_LOG2+2] == BASE_ADDR[same]; word index = addr[DEPTH_LOG2+1:2]; addr[1:0] ignored.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE. awready=1 only in W_IDLE. AW accepted cycle N: latch id, index, len, burst, err; wready=1 from N+1 in W_DATA.
- Each accepted W beat: if no err, write bytes with wstrb[i]=1; then advance index (INCR: +1 mod 2^DEPTH_LOG2; FIXED: hold).
- Beat count, not wlast, ends the burst: after beat awlen+1, wready drops, bvalid=1 next cycle. bvalid held until bready; return to W_IDLE the cycle after the B handshake.
- bresp: 2'b11 DECERR if miss (writes dropped); else 2'b10 SLVERR if awburst==WRAP/reserved (writes dropped) or wlast mismatched (asserted early or missing on final beat; data still written); else 2'b00.
- Read FSM R_IDLE -> R_DATA -> R_IDLE. arready=1 only in R_IDLE. AR accepted cycle N: rvalid=1 at N+1 with beat 0; each rvalid&rready loads the next beat in the following cycle (one beat/cycle at full throughput); rlast=1 on beat arlen; R_IDLE the cycle after the last handshake.
- rdata/rresp/rlast held stable while rvalid&!rready. Miss -> rresp 2'b11, rdata 0; WRAP/reserved -> 2'b10, rdata 0; all beats carry same resp.
- Read and write channels are independent and may be active concurrently. Same-cycle write and beat-load of the same word: read returns pre-write value.
- scratch_out updates the cycle after any byte-0 write to word 0.

Test Plan:
- Single write 32'hCAFE_F00D to BASE+0x4, wstrb 4'hF, then read 0x4 -> bresp 00, rdata CAFE_F00D, rlast 1, rid echoes arid.
- wstrb 4'b0101 write 32'h1122_3344 over CAFE_F00D at 0x4 -> readback CA22_F044.
- INCR awlen=3 from word 14 (DEPTH_LOG2=4), data 1,2,3,4 -> words 14,15,0,1 written; INCR arlen=3 read returns 1,2,3,4, rlast only on beat 3, with rready toggled every other cycle.
- Write to BASE+0x100 -> bresp 11, array unchanged; read there -> rresp 11, rdata 0.
- Write 8'hA5 to word 0 -> scratch_out A5 one cycle after W beat; aresetn pulse mid-read burst -> rvalid 0 immediately, scratch_out 0, word 0 reads back 0.
- awlen=1 with wlast on beat 0 -> both beats accepted, bresp 10; concurrent read of unrelated word completes with rresp 00.
